// File: rtl/sigdel_pkg.sv
// Shared types and default constants for the sigma-delta measurement scheduler.
package sigdel_pkg;

  localparam int NCH_D    = 4;   // requesting channels
  localparam int W_D      = 8;   // modulator input width
  localparam int SETTLE_D = 4;   // post-clear cycles whose bitstream is ignored
  localparam int DWELL_D  = 16;  // measurement window length

  // Measurement sequence for one granted channel.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SETTLE,
    ST_WINDOW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sigdel_sched_if.sv
// Requester/modulator/result signals of the scheduler, bundled as one port.
// master: the environment (requesters + modulator); slave: the scheduler.
interface sigdel_sched_if
  import sigdel_pkg::*;
#(
  parameter int NCH   = NCH_D,
  parameter int W     = W_D,
  parameter int DWELL = DWELL_D
);
  localparam int CW = $clog2(DWELL + 1);
  localparam int SW = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] ch_val;
  logic [NCH-1:0]   grant;
  logic [W-1:0]     mod_inp;
  logic             mod_clr;
  logic             mod_bit;
  logic [CW-1:0]    result;
  logic [SW-1:0]    result_ch;
  logic             result_valid;
  logic             busy;

  modport master (
    output req, ch_val, mod_bit,
    input  grant, mod_inp, mod_clr, result, result_ch, result_valid, busy
  );

  modport slave (
    input  req, ch_val, mod_bit,
    output grant, mod_inp, mod_clr, result, result_ch, result_valid, busy
  );

endinterface

// File: rtl/sigdel_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sigdel_rr_pick
  import sigdel_pkg::*;
#(
  parameter int NCH = NCH_D,
  localparam int SW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  ptr_i,
  output logic           any_o,
  output logic [SW-1:0]  idx_o,
  output logic [NCH-1:0] onehot_o
);

  // Candidate channel at each priority rank; wrap is an explicit compare so
  // non-power-of-2 channel counts stay in range.
  logic [SW-1:0] cand [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    assign cand[gi] = ((int'(ptr_i) + gi) >= NCH) ? SW'(int'(ptr_i) + gi - NCH)
                                                  : SW'(int'(ptr_i) + gi);
  end

  // Scan from lowest priority upward so the highest-priority hit wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        any_o = 1'b1;
        idx_o = cand[k];
      end
    end
  end

  assign onehot_o = any_o ? (NCH'(1) << idx_o) : '0;

endmodule

// File: rtl/sigdel_sched.sv
// Shares one sigma-delta modulator among NCH requesters: per grant it clears the
// modulator, waits out the settle time, counts ones over a fixed window and
// reports the count with the channel number.
module sigdel_sched
  import sigdel_pkg::*;
#(
  parameter int NCH    = NCH_D,
  parameter int W      = W_D,
  parameter int SETTLE = SETTLE_D,
  parameter int DWELL  = DWELL_D
) (
  input  logic           clk,
  input  logic           rst_n,
  sigdel_sched_if.slave  bus
);

  localparam int CW   = $clog2(DWELL + 1);
  localparam int SW   = $clog2(NCH);
  localparam int PMAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int PW   = $clog2(PMAX + 1);

  state_t          state_q;
  logic [SW-1:0]   sel_q;
  logic [SW-1:0]   ptr_q;
  logic [NCH-1:0]  grant_q;
  logic            mod_clr_q;
  logic            active_q;     // CLR/SETTLE/WINDOW: modulator input is live
  logic [PW-1:0]   cnt_q;        // phase counter for SETTLE and WINDOW
  logic [CW-1:0]   acc_q;
  logic [CW-1:0]   result_q;
  logic [SW-1:0]   result_ch_q;
  logic            result_valid_q;

  logic            pick_any;
  logic [SW-1:0]   pick_idx;
  logic [NCH-1:0]  pick_onehot;
  logic [SW-1:0]   ptr_after_sel;
  logic            req_sel;
  logic [CW-1:0]   acc_plus_bit;

  sigdel_rr_pick #(.NCH(NCH)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign ptr_after_sel = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + 1'b1;
  assign req_sel       = bus.req[sel_q];
  assign acc_plus_bit  = acc_q + CW'(bus.mod_bit);

  // Measurement FSM with its counters, pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sel_q          <= '0;
      ptr_q          <= '0;
      grant_q        <= '0;
      mod_clr_q      <= 1'b0;
      active_q       <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      mod_clr_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            sel_q     <= pick_idx;
            grant_q   <= pick_onehot;
            mod_clr_q <= 1'b1;
            active_q  <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            state_q   <= ST_CLR;
          end
        end
        ST_CLR, ST_SETTLE, ST_WINDOW: begin
          if (!req_sel) begin
            // Granted requester withdrew: drop the measurement silently.
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            active_q <= 1'b0;
            ptr_q    <= ptr_after_sel;
          end else begin
            case (state_q)
              ST_CLR: begin
                cnt_q   <= '0;
                state_q <= ST_SETTLE;
              end
              ST_SETTLE: begin
                if (cnt_q == PW'(SETTLE - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_WINDOW;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              default: begin
                acc_q <= acc_plus_bit;
                if (cnt_q == PW'(DWELL - 1)) begin
                  result_q       <= acc_plus_bit;
                  result_ch_q    <= sel_q;
                  result_valid_q <= 1'b1;
                  grant_q        <= '0;
                  active_q       <= 1'b0;
                  ptr_q          <= ptr_after_sel;
                  state_q        <= ST_DONE;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
            endcase
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.mod_clr      = mod_clr_q;
  assign bus.mod_inp      = active_q ? bus.ch_val[sel_q*W +: W] : '0;
  assign bus.result       = result_q;
  assign bus.result_ch    = result_ch_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sigdel_sched.sv
// Randomized bench for sigdel_sched against a transaction-level model.
module tb_sigdel_sched;
  import sigdel_pkg::*;

  localparam int NCH    = 4;
  localparam int W      = 8;
  localparam int SETTLE = 4;
  localparam int DWELL  = 16;
  localparam int LAST   = 2 + SETTLE + DWELL;   // cycle of result_valid
  localparam int WIN_LO = 2 + SETTLE;
  localparam int WIN_HI = LAST - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigdel_sched_if #(.NCH(NCH), .W(W), .DWELL(DWELL)) bus ();

  sigdel_sched #(.NCH(NCH), .W(W), .SETTLE(SETTLE), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: round-robin pointer and last reported result.
  int m_ptr = 0;
  int m_res = 0;
  int m_ch  = 0;

  logic [W-1:0] cv [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] rq, input int ptr);
    for (int k = 0; k < NCH; k++) begin
      if (rq[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  // Bitstream pattern: 0 random, 1 all ones, 2 ones in settle then 1/0 in window, 3 zeros.
  function automatic logic bit_for(input int mode, input int c);
    case (mode)
      0: return 1'($urandom % 2);
      1: return 1'b1;
      2: begin
        if (c >= 2 && c < WIN_LO) return 1'b1;
        if (c >= WIN_LO && c <= WIN_HI) return ((c - WIN_LO) % 2) == 0;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply_cv();
    for (int i = 0; i < NCH; i++) bus.ch_val[i*W +: W] = cv[i];
  endtask

  // One measurement starting in the current (IDLE) cycle, called as cycle 0.
  task automatic meas(input logic [NCH-1:0] rq, input int mode, input int abort_at,
                      input int rst_at, input bit wiggle);
    int ch;
    int ones;
    logic b;
    logic [NCH-1:0] r;
    ch   = pick(rq, m_ptr);
    ones = 0;
    bus.req     = rq;
    bus.mod_bit = 1'b0;
    apply_cv();
    for (int c = 1; c <= LAST + 1; c++) begin
      @(posedge clk); #1;
      if (c == LAST + 1) begin
        chk("idle_grant", bus.grant, 0);
        chk("idle_busy", bus.busy, 0);
        break;
      end
      if (c == LAST) begin
        chk("done_valid", bus.result_valid, 1);
        chk("done_result", bus.result, ones);
        chk("done_ch", bus.result_ch, ch);
        chk("done_grant", bus.grant, 0);
        chk("done_inp", bus.mod_inp, 0);
        chk("done_clr", bus.mod_clr, 0);
        chk("done_busy", bus.busy, 1);
      end else begin
        chk("run_valid", bus.result_valid, 0);
        chk("run_grant", bus.grant, 32'(1) << ch);
        chk("run_clr", bus.mod_clr, (c == 1) ? 1 : 0);
        chk("run_inp", bus.mod_inp, cv[ch]);
        chk("run_hold", bus.result, m_res);
        chk("run_busy", bus.busy, 1);
      end
      b = bit_for(mode, c);
      bus.mod_bit = b;
      if (c >= WIN_LO && c <= WIN_HI && b) ones++;
      if (wiggle) begin
        r = NCH'($urandom);
        r[ch] = 1'b1;
        bus.req = r;
        for (int i = 0; i < NCH; i++) if (i != ch) cv[i] = W'($urandom);
        apply_cv();
      end
      if (c == abort_at) begin
        bus.req[ch] = 1'b0;
        @(posedge clk); #1;
        chk("abort_grant", bus.grant, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.result_valid, 0);
        chk("abort_result", bus.result, m_res);
        chk("abort_ch", bus.result_ch, m_ch);
        chk("abort_inp", bus.mod_inp, 0);
        m_ptr = (ch + 1) % NCH;
        $display("abort ch=%0d at cycle %0d", ch, c);
        return;
      end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", bus.grant, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.result_valid, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_ch", bus.result_ch, 0);
        chk("arst_clr", bus.mod_clr, 0);
        chk("arst_inp", bus.mod_inp, 0);
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0;
        m_res = 0;
        m_ch  = 0;
        $display("reset during ch=%0d at cycle %0d", ch, c);
        return;
      end
    end
    m_res = ones;
    m_ch  = ch;
    m_ptr = (ch + 1) % NCH;
    $display("meas ch=%0d req=%b mode=%0d result=%0d", ch, rq, mode, ones);
  endtask

  initial begin
    logic [NCH-1:0] rq;
    int mode;
    int ab;
    bus.req     = '0;
    bus.ch_val  = '0;
    bus.mod_bit = 1'b0;
    for (int i = 0; i < NCH; i++) cv[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ch", bus.result_ch, 0);
    chk("rst_clr", bus.mod_clr, 0);
    chk("rst_inp", bus.mod_inp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, ones throughout; channel 1 carries 8'hA5.
    for (int i = 0; i < NCH; i++) cv[i] = W'($urandom);
    cv[1] = 8'hA5;
    meas(4'b0010, 1, 0, 0, 1'b0);

    // Settle masking.
    meas(4'b0001, 2, 0, 0, 1'b0);

    // Asynchronous reset in the middle of the window.
    meas(4'b1111, 3, 0, WIN_LO + 6, 1'b0);

    // Round-robin with all channels requesting: 0,1,2,3,0.
    repeat (5) meas(4'b1111, 3, 0, 0, 1'b0);

    // Abort of channel 2 at window cycle 5, then 1011 goes to channel 3.
    meas(4'b1111, 3, 0, 0, 1'b0);
    meas(4'b1111, 3, WIN_LO + 5, 0, 1'b0);
    meas(4'b1011, 3, 0, 0, 1'b0);

    // Randomized measurements with activity on the other channels.
    for (int n = 0; n < 40; n++) begin
      rq   = NCH'($urandom_range(1, (1 << NCH) - 1));
      mode = int'($urandom % 4);
      ab   = ($urandom % 5 == 0) ? int'($urandom_range(1, LAST - 1)) : 0;
      for (int i = 0; i < NCH; i++) cv[i] = W'($urandom);
      meas(rq, mode, ab, 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
